audio_stream_mixer: RTL and testbench
=====================================

# audio_stream_mixer

Multi-voice sample mixer and output buffer between the synth/voice logic and the board's `Audio_Controller`.
- Accepts `NUM_CH` signed sample streams over valid/ready, applies per-channel 8-bit gain, mute and left/right routing, and sums each channel set into one stereo frame.
- Queues frames in a `FIFO_DEPTH`-entry buffer.
- Drains the buffer into the controller's `audio_out_allowed`/`write_audio_out` handshake.

## Interface
Parameters:
- `NUM_CH`, 4: number of input voices (1..8).
- `SAMPLE_W`, 16: input sample width, signed two's complement.
- `OUT_W`, 32: controller sample width; must be >= `SAMPLE_W`.
- `FIFO_DEPTH`, 8: stereo frame buffer depth, power of 2, >= 2.

Ports:
- `CLOCK_50`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `ch_data`, in, `NUM_CH*SAMPLE_W`: channel i occupies bits `[i*SAMPLE_W +: SAMPLE_W]`.
- `ch_valid`, in, `NUM_CH`: per-channel sample valid.
- `ch_ready`, out, `NUM_CH`: per-channel accept.
- `ch_gain`, in, `NUM_CH*8`: unsigned gain; 128 is unity, 255 is about 1.99x.
- `ch_mute`, in, `NUM_CH`: a muted channel contributes 0 but is still consumed.
- `ch_left_en`, in, `NUM_CH`: route channel to the left sum.
- `ch_right_en`, in, `NUM_CH`: route channel to the right sum.
- `audio_out_allowed`, in, 1: controller has output space.
- `write_audio_out`, out, 1: one-cycle write strobe to the controller.
- `left_channel_audio_out`, out, `OUT_W`: left sample to the controller.
- `right_channel_audio_out`, out, `OUT_W`: right sample to the controller.
- `fifo_level`, out, `clog2(FIFO_DEPTH)+1`: frames currently buffered.
- `underrun_cnt`, out, 8: saturating count of starvation intervals.

## Operation
- **GATHER state:** `ch_ready[i]` = not yet captured[i] and FIFO not full.
  - On `ch_valid[i] && ch_ready[i]`, the sample is latched into hold register i and captured[i] is set.
  - When all `NUM_CH` captured bits are set, go to MIX and clear both accumulators.
- **MIX state:** one channel per cycle, index k = 0..`NUM_CH`-1.
  - term = mute[k] ? 0 : (hold[k] * gain[k]), signed * unsigned.
  - Width of term is `SAMPLE_W+9`.
  - term is added to accL if `left_en[k]` and to accR if `right_en[k]`.
  - Accumulator width is `SAMPLE_W+9+clog2(NUM_CH)`.
  - `ch_gain`, `ch_mute` and the route enables are sampled at the cycle channel k is mixed.
  - After k = `NUM_CH`-1, go to PUSH.
- **PUSH state:**
  - Each accumulator is arithmetic-shifted right by 7, then reduced to `SAMPLE_W` bits (see Configuration).
  - Each result is placed left-aligned in `OUT_W`: bits `[OUT_W-1 -: SAMPLE_W]` = sample, lower bits 0.
  - The frame is written to the FIFO. Space is guaranteed because FIFO not full was required in GATHER.
  - Captured bits clear and the state returns to GATHER.
- **Drain:**
  - When `audio_out_allowed` && FIFO not empty && `write_audio_out` was low last cycle:
    - pop the head;
    - register it onto `left/right_channel_audio_out`;
    - assert `write_audio_out` for exactly one cycle.
  - Writes are never back-to-back; this is the minimum one idle cycle for the controller flag update.
  - Output data holds its value until the next pop.
- **Underrun:**
  - A starved flag sets when `audio_out_allowed` && FIFO empty && flag clear; `underrun_cnt` increments (saturates at 255) at that set.
  - The flag clears on the next pop.
- **Simultaneous push and pop:** allowed in the same cycle; `fifo_level` is unchanged.
- **Pointers:** wrap modulo `FIFO_DEPTH`.

## Timing
- Reset values:
  - state = GATHER, captured = 0, accumulators = 0.
  - FIFO empty, `fifo_level` = 0.
  - `ch_ready` = 0 during reset, all 1 in the first cycle after reset.
  - `write_audio_out` = 0, `left/right_channel_audio_out` = 0.
  - `underrun_cnt` = 0, starved flag clear.
- Latency: the last sample accepted at cycle t is in the FIFO at t+`NUM_CH`+2, and appears at the output at t+`NUM_CH`+3 at the earliest.
- Throughput: at most one frame per `NUM_CH`+2 cycles.
- FIFO full: `ch_ready` is all 0; channels already captured stay captured.
- Reset mid-MIX or mid-PUSH discards the partial frame and the FIFO contents.
- `ch_ready` is registered-state based, with no combinational path from `ch_valid`.

## Configuration
- `AUDIO_MIX_SAT_EN` defined: out-of-range shifted sums clamp to +(2^(`SAMPLE_W`-1)-1) or -2^(`SAMPLE_W`-1).
- Undefined: the low `SAMPLE_W` bits are kept, giving two's-complement wrap.

## Test plan
- **Unity mix:** after reset, `NUM_CH`=4, gains 128, all routes on, samples 100/200/-50/0, `audio_out_allowed`=1.
  - One `write_audio_out` pulse; left = right = 250<<16 (0x00FA0000) at accept+7.
- **Routing/mute:** ch0 = 1000 left only, ch1 = 2000 right only, ch2 muted = 30000, ch3 = 0, gains 128.
  - Left = 1000<<16, right = 2000<<16.
- **Saturation:** all channels 0x7FFF, gain 255.
  - With `AUDIO_MIX_SAT_EN`: output 0x7FFF0000.
  - Without: the low 16 bits of (4*0x7FFF*255)>>7.
- **Backpressure:** hold `audio_out_allowed`=0 while feeding 10 frames with `FIFO_DEPTH`=8.
  - `fifo_level` reaches 8 and `ch_ready` drops to 0.
  - On release, 8 write pulses spaced >= 2 cycles, in order, no loss.
- **Underrun:** FIFO empty with `audio_out_allowed`=1 for 50 cycles.
  - `underrun_cnt`=1; one frame pushed and popped; starve again gives 2.
- **Reset mid-frame:** assert `reset` during MIX.
  - All outputs at reset values next cycle, no write pulse, new frame mixes correctly.

Source files
------------

// File: rtl/audio_stream_mixer.sv
// Multi-voice gain/route/mute mixer with a stereo frame FIFO feeding the Audio_Controller write handshake.
// Define AUDIO_MIX_SAT_EN to clamp out-of-range mixes; otherwise the result wraps.

module audio_mix_lane #(
  parameter int SAMPLE_W = 16
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] data,
  input  logic                valid,
  input  logic                enable,
  input  logic                clear,
  output logic                ready,
  output logic                captured,
  output logic                cap_next,
  output logic [SAMPLE_W-1:0] hold
);
  assign ready    = enable & ~captured;
  assign cap_next = captured | (valid & ready);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      captured <= 1'b0;
      hold     <= '0;
    end else if (clear) begin
      captured <= 1'b0;
    end else if (valid && ready) begin
      captured <= 1'b1;
      hold     <= data;
    end
  end
endmodule

module audio_stream_mixer #(
  parameter int NUM_CH     = 4,
  parameter int SAMPLE_W   = 16,
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic [NUM_CH*SAMPLE_W-1:0]    ch_data,
  input  logic [NUM_CH-1:0]             ch_valid,
  output logic [NUM_CH-1:0]             ch_ready,
  input  logic [NUM_CH*8-1:0]           ch_gain,
  input  logic [NUM_CH-1:0]             ch_mute,
  input  logic [NUM_CH-1:0]             ch_left_en,
  input  logic [NUM_CH-1:0]             ch_right_en,
  input  logic                          audio_out_allowed,
  output logic                          write_audio_out,
  output logic [OUT_W-1:0]              left_channel_audio_out,
  output logic [OUT_W-1:0]              right_channel_audio_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    underrun_cnt
);
  localparam int TERM_W = SAMPLE_W + 9;
  localparam int ACC_W  = SAMPLE_W + 9 + $clog2(NUM_CH);
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {S_GATHER, S_MIX, S_PUSH} state_t;
  state_t state, state_nxt;

  logic [NUM_CH-1:0]               cap_q, cap_nxt;
  logic [NUM_CH-1:0][SAMPLE_W-1:0] hold_q;
  logic                            fifo_full, fifo_empty, gather_en;
  logic                            push, pop;

  assign gather_en = ~reset & (state == S_GATHER) & ~fifo_full;

  // Per-voice capture: hold register plus captured flag
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    audio_mix_lane #(.SAMPLE_W(SAMPLE_W)) u_lane (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .data     (ch_data[i*SAMPLE_W +: SAMPLE_W]),
      .valid    (ch_valid[i]),
      .enable   (gather_en),
      .clear    (state == S_PUSH),
      .ready    (ch_ready[i]),
      .captured (cap_q[i]),
      .cap_next (cap_nxt[i]),
      .hold     (hold_q[i])
    );
  end

  logic [IDX_W-1:0] mix_idx;

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= S_GATHER;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_GATHER: if (&cap_nxt) state_nxt = S_MIX;
      S_MIX:    if (mix_idx == LAST_IDX) state_nxt = S_PUSH;
      S_PUSH:   state_nxt = S_GATHER;
      default:  state_nxt = S_GATHER;
    endcase
  end

  // Controls are picked for the channel being mixed this cycle
  logic signed [SAMPLE_W-1:0] hold_k;
  logic [7:0]                 gain_k;
  logic                       mute_k, len_k, ren_k;
  logic signed [TERM_W-1:0]   term;

  always_comb begin
    hold_k = '0;
    gain_k = '0;
    mute_k = 1'b0;
    len_k  = 1'b0;
    ren_k  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mix_idx == IDX_W'(i)) begin
        hold_k = $signed(hold_q[i]);
        gain_k = ch_gain[i*8 +: 8];
        mute_k = ch_mute[i];
        len_k  = ch_left_en[i];
        ren_k  = ch_right_en[i];
      end
    end
    term = '0;
    if (!mute_k) term = hold_k * $signed({1'b0, gain_k});
  end

  logic signed [ACC_W-1:0] acc_l, acc_r;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      acc_l   <= '0;
      acc_r   <= '0;
      mix_idx <= '0;
    end else begin
      case (state)
        S_GATHER: if (state_nxt == S_MIX) begin
          acc_l   <= '0;
          acc_r   <= '0;
          mix_idx <= '0;
        end
        S_MIX: begin
          if (len_k) acc_l <= acc_l + ACC_W'(term);
          if (ren_k) acc_r <= acc_r + ACC_W'(term);
          mix_idx <= mix_idx + 1'b1;
        end
        default: mix_idx <= '0;
      endcase
    end
  end

`ifdef AUDIO_MIX_SAT_EN
  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
`endif

  // Undo the 128 = unity gain scaling, then fit the sum back into SAMPLE_W
  function automatic logic [SAMPLE_W-1:0] reduce(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> 7;
`ifdef AUDIO_MIX_SAT_EN
    if (s > SMAX)      return SMAX[SAMPLE_W-1:0];
    else if (s < SMIN) return SMIN[SAMPLE_W-1:0];
    else               return s[SAMPLE_W-1:0];
`else
    return s[SAMPLE_W-1:0];
`endif
  endfunction

  // Frame FIFO
  logic [2*SAMPLE_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [LVL_W-1:0]      level;

  assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  assign push       = (state == S_PUSH);
  assign pop        = audio_out_allowed & ~fifo_empty & ~write_audio_out;
  assign fifo_level = level;

  always_ff @(posedge CLOCK_50) begin
    if (push) fifo_mem[wr_ptr] <= {reduce(acc_l), reduce(acc_r)};
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  logic [2*SAMPLE_W-1:0] head;
  logic [OUT_W-1:0]      pad_l, pad_r;

  assign head = fifo_mem[rd_ptr];

  always_comb begin
    pad_l = '0;
    pad_r = '0;
    pad_l[OUT_W-1 -: SAMPLE_W] = head[2*SAMPLE_W-1 -: SAMPLE_W];
    pad_r[OUT_W-1 -: SAMPLE_W] = head[SAMPLE_W-1:0];
  end

  // Strobe is one cycle wide and never back-to-back, giving the controller a cycle to update its flag
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      write_audio_out         <= 1'b0;
      left_channel_audio_out  <= '0;
      right_channel_audio_out <= '0;
    end else begin
      write_audio_out <= pop;
      if (pop) begin
        left_channel_audio_out  <= pad_l;
        right_channel_audio_out <= pad_r;
      end
    end
  end

  logic starved;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      starved      <= 1'b0;
      underrun_cnt <= '0;
    end else if (pop) begin
      starved <= 1'b0;
    end else if (audio_out_allowed && fifo_empty && !starved) begin
      starved <= 1'b1;
      if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_audio_stream_mixer.sv
// Directed bench for audio_stream_mixer: expected frames queued at issue, checked by a monitor on each write strobe.
module tb_audio_stream_mixer;
  localparam int NUM_CH = 4, SAMPLE_W = 16, OUT_W = 32, FIFO_DEPTH = 8;

  logic                       CLOCK_50, reset;
  logic [NUM_CH*SAMPLE_W-1:0] ch_data;
  logic [NUM_CH-1:0]          ch_valid, ch_ready, ch_mute, ch_left_en, ch_right_en;
  logic [NUM_CH*8-1:0]        ch_gain;
  logic                       audio_out_allowed, write_audio_out;
  logic [OUT_W-1:0]           left_channel_audio_out, right_channel_audio_out;
  logic [3:0]                 fifo_level;
  logic [7:0]                 underrun_cnt;

  audio_stream_mixer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .ch_data(ch_data), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_gain(ch_gain), .ch_mute(ch_mute), .ch_left_en(ch_left_en), .ch_right_en(ch_right_en),
    .audio_out_allowed(audio_out_allowed), .write_audio_out(write_audio_out),
    .left_channel_audio_out(left_channel_audio_out), .right_channel_audio_out(right_channel_audio_out),
    .fifo_level(fifo_level), .underrun_cnt(underrun_cnt)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic [63:0] exp_q[$];
  int          n_checks = 0, n_fail = 0;
  bit          feed_done;

`ifdef AUDIO_MIX_SAT_EN
  localparam logic [31:0] SAT_EXP = 32'h7FFF0000;
`else
  localparam logic [31:0] SAT_EXP = 32'hFBF80000;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
    #1;
  endtask

  // Monitor: every strobe pops one expected frame; strobes must never be adjacent
  logic        mon_prev = 1'b0;
  logic [63:0] mon_e;
  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (write_audio_out === 1'b1) begin
        check("wr_gap", 64'(mon_prev), 64'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got L=%0h R=%0h expected no write",
                   left_channel_audio_out, right_channel_audio_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_left",  64'(left_channel_audio_out),  64'(mon_e[63:32]));
          check("out_right", 64'(right_channel_audio_out), 64'(mon_e[31:0]));
        end
      end
      mon_prev = write_audio_out;
    end
  end

  task automatic send(input logic [15:0] d0, d1, d2, d3, input bit exp_it,
                      input logic [31:0] el, input logic [31:0] er);
    logic [3:0] fired;
    int cnt;
    if (exp_it) exp_q.push_back({el, er});
    ch_data  = {d3, d2, d1, d0};
    ch_valid = '1;
    cnt      = 0;
    while (ch_valid != 0 && cnt < 3000) begin
      #1;
      fired = ch_valid & ch_ready;
      @(negedge CLOCK_50);
      ch_valid = ch_valid & ~fired;
      cnt++;
    end
    #1;
    if (ch_valid != 0) begin
      check("send_timeout", 64'(ch_valid), 64'd0);
      ch_valid = '0;
    end
  endtask

  task automatic wait_drain(input string name);
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < 600) begin
      tick(1);
      cnt++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    tick(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset = 1'b1; ch_data = '0; ch_valid = '0; audio_out_allowed = 1'b0;
    ch_gain = {4{8'd128}}; ch_mute = '0; ch_left_en = '1; ch_right_en = '1;
    feed_done = 1'b0;

    // Reset values
    tick(3);
    check("rst_ready", 64'(ch_ready), 64'd0);
    reset = 1'b0;
    tick(1);
    check("post_rst_ready", 64'(ch_ready), 64'hF);
    check("rst_write", 64'(write_audio_out), 64'd0);
    check("rst_left", 64'(left_channel_audio_out), 64'd0);
    check("rst_right", 64'(right_channel_audio_out), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_underrun", 64'(underrun_cnt), 64'd0);

    // Unity mix with latency: strobe first seen 7 cycles after accept
    audio_out_allowed = 1'b1;
    send(16'd100, 16'd200, -16'sd50, 16'd0, 1, 32'h00FA0000, 32'h00FA0000);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("lat_early", 64'(write_audio_out), 64'd0);
    end
    tick(1);
    check("lat_write", 64'(write_audio_out), 64'd1);
    wait_drain("drain_unity");

    // Routing and mute
    ch_left_en = 4'b1101; ch_right_en = 4'b1110; ch_mute = 4'b0100;
    send(16'd1000, 16'd2000, 16'd30000, 16'd0, 1, 32'h03E80000, 32'h07D00000);
    wait_drain("drain_route");

    // Full-scale mix at max gain
    ch_left_en = '1; ch_right_en = '1; ch_mute = '0; ch_gain = {4{8'd255}};
    send(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1, SAT_EXP, SAT_EXP);
    wait_drain("drain_sat");

    // Negative samples, half gain: arithmetic shift keeps the sign
    ch_gain = {4{8'd64}}; ch_right_en = 4'b0001;
    send(16'hFF9C, 16'hFF9C, 16'hFF9C, 16'hFF9C, 1, 32'hFF380000, 32'hFFCE0000);
    wait_drain("drain_neg");

    // Backpressure: 10 frames into an 8-deep FIFO with the controller stalled
    ch_gain = {4{8'd128}}; ch_right_en = '1;
    audio_out_allowed = 1'b0;
    fork
      begin
        for (int f = 0; f < 10; f++)
          send(16'(10*(f+1)), 16'd0, 16'd0, 16'd0, 1, 32'(10*(f+1)) << 16, 32'(10*(f+1)) << 16);
        feed_done = 1'b1;
      end
    join_none
    cnt = 0;
    while (fifo_level != 4'd8 && cnt < 500) begin tick(1); cnt++; end
    check("bp_level_full", 64'(fifo_level), 64'd8);
    tick(4);
    check("bp_ready_low", 64'(ch_ready), 64'd0);
    check("bp_level_hold", 64'(fifo_level), 64'd8);
    audio_out_allowed = 1'b1;
    cnt = 0;
    while (!feed_done && cnt < 600) begin tick(1); cnt++; end
    check("bp_feed_done", 64'(feed_done), 64'd1);
    wait_drain("drain_bp");
    check("bp_level_empty", 64'(fifo_level), 64'd0);

    // Reset during MIX discards the partial frame and the buffered one
    audio_out_allowed = 1'b0;
    send(16'd5, 16'd5, 16'd5, 16'd5, 0, '0, '0);
    tick(8);
    check("mid_level_one", 64'(fifo_level), 64'd1);
    send(16'd9, 16'd9, 16'd9, 16'd9, 0, '0, '0);
    tick(1);
    reset = 1'b1;
    tick(1);
    check("mid_rst_write", 64'(write_audio_out), 64'd0);
    check("mid_rst_left", 64'(left_channel_audio_out), 64'd0);
    check("mid_rst_level", 64'(fifo_level), 64'd0);
    check("mid_rst_ready", 64'(ch_ready), 64'd0);
    reset = 1'b0;
    tick(12);
    check("mid_level_after", 64'(fifo_level), 64'd0);
    check("mid_underrun", 64'(underrun_cnt), 64'd0);

    // Underrun counting, and a fresh frame mixes correctly after the reset
    audio_out_allowed = 1'b1;
    tick(50);
    check("underrun_one", 64'(underrun_cnt), 64'd1);
    send(16'd300, -16'sd100, 16'd50, 16'd7, 1, 32'h01010000, 32'h01010000);
    wait_drain("drain_after_rst");
    tick(3);
    check("underrun_two", 64'(underrun_cnt), 64'd2);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
